// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/almost-empty
// flags, one-cycle overflow/underflow pulses and an optional
// first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_W       = 128,
    parameter int DEPTH        = 16,
    parameter int ALM_FULL_TH  = 14,
    parameter int ALM_EMPTY_TH = 2,
    parameter int FWFT         = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wren,
    input  logic [DATA_W-1:0]        i_wrdata,
    input  logic                     i_rden,
    output logic [DATA_W-1:0]        o_rddata,
    output logic                     o_full,
    output logic                     o_alm_full,
    output logic                     o_empty,
    output logic                     o_alm_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(ALM_FULL_TH);
    localparam logic [CW-1:0] AEMPT_CNT = CW'(ALM_EMPTY_TH);

    // Request/accept protocol: i_wren and i_rden are requests with no ready
    // handshake back. A read is accepted on an edge when the FIFO is not
    // empty; a write is accepted when the FIFO is not full, or when it is
    // full and a read is accepted on the same edge. A request that is not
    // accepted is dropped and reported by an overflow/underflow pulse in
    // the following cycle. All acceptance uses the pre-edge state.

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              rd_acc;
    logic              wr_acc;

    // Flags decode straight from the count register.
    always_comb begin
        o_count     = count;
        o_empty     = (count == '0);
        o_full      = (count == FULL_CNT);
        o_alm_full  = (count >= AFULL_CNT);
        o_alm_empty = (count <= AEMPT_CNT);
        rd_acc      = i_rden & ~o_empty;
        wr_acc      = i_wren & (~o_full | rd_acc);
    end

    // Storage array; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= i_wrdata;
        end
    end

    // Pointers, fill level and the self-clearing error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count <= count - 1'b1;
            end
            o_overflow  <= i_wren & ~wr_acc;
            o_underflow <= i_rden & ~rd_acc;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always presented; meaningless while empty.
            always_comb begin
                o_rddata = mem[rd_ptr];
            end
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q;

            // Registered read: load the head on an accepted read, else hold.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q <= '0;
                end else if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end

            // Drive the port from the read register.
            always_comb begin
                o_rddata = rd_data_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-read instance and one
// fall-through instance, each compared every cycle against a queue model.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic clk;

    // Standard-read instance signals.
    logic          rst0, wren0, rden0;
    logic [DW-1:0] wrdata0, rddata0;
    logic          full0, afull0, empty0, aempty0, ovf0, udf0;
    logic [4:0]    count0;

    // Fall-through instance signals.
    logic          rst1, wren1, rden1;
    logic [DW-1:0] wrdata1, rddata1;
    logic          full1, afull1, empty1, aempty1, ovf1, udf1;
    logic [4:0]    count1;

    int errors = 0;
    int checks = 0;

    // Scoreboards and model state.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fq[$];
    int            m0_cnt;
    int            m1_cnt;
    logic [DW-1:0] m0_last;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_TH(14),
                      .ALM_EMPTY_TH(2), .FWFT(0)) dut0 (
        .clk(clk), .reset(rst0), .i_wren(wren0), .i_wrdata(wrdata0),
        .i_rden(rden0), .o_rddata(rddata0), .o_full(full0),
        .o_alm_full(afull0), .o_empty(empty0), .o_alm_empty(aempty0),
        .o_count(count0), .o_overflow(ovf0), .o_underflow(udf0)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .ALM_FULL_TH(14),
                      .ALM_EMPTY_TH(2), .FWFT(1)) dut1 (
        .clk(clk), .reset(rst1), .i_wren(wren1), .i_wrdata(wrdata1),
        .i_rden(rden1), .o_rddata(rddata1), .o_full(full1),
        .o_alm_full(afull1), .o_empty(empty1), .o_alm_empty(aempty1),
        .o_count(count1), .o_overflow(ovf1), .o_underflow(udf1)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input logic e_ovf, input logic e_udf);
        chk("count0", 32'(count0), 32'(m0_cnt));
        chk("empty0", 32'(empty0), 32'(m0_cnt == 0));
        chk("full0", 32'(full0), 32'(m0_cnt == DEPTH));
        chk("alm_empty0", 32'(aempty0), 32'(m0_cnt <= 2));
        chk("alm_full0", 32'(afull0), 32'(m0_cnt >= 14));
        chk("overflow0", 32'(ovf0), 32'(e_ovf));
        chk("underflow0", 32'(udf0), 32'(e_udf));
        chk("rddata0", 32'(rddata0), 32'(m0_last));
    endtask

    task automatic chk1(input logic e_ovf, input logic e_udf);
        chk("count1", 32'(count1), 32'(m1_cnt));
        chk("empty1", 32'(empty1), 32'(m1_cnt == 0));
        chk("full1", 32'(full1), 32'(m1_cnt == DEPTH));
        chk("overflow1", 32'(ovf1), 32'(e_ovf));
        chk("underflow1", 32'(udf1), 32'(e_udf));
        if (m1_cnt != 0) begin
            chk("rddata1", 32'(rddata1), 32'(fq[0]));
        end
    endtask

    // One clock of traffic on the standard-read instance.
    task automatic cyc0(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic ra, wa;
        ra = rd && (m0_cnt != 0);
        wa = wr && ((m0_cnt != DEPTH) || ra);
        wren0 = wr; wrdata0 = d; rden0 = rd;
        if (ra) m0_last = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        if (wa && !ra) m0_cnt++;
        else if (ra && !wa) m0_cnt--;
        @(posedge clk); #1;
        wren0 = 1'b0; rden0 = 1'b0;
        chk0(wr && !wa, rd && !ra);
    endtask

    // One clock of traffic on the fall-through instance.
    task automatic cyc1(input logic wr, input logic [DW-1:0] d, input logic rd);
        logic ra, wa;
        ra = rd && (m1_cnt != 0);
        wa = wr && ((m1_cnt != DEPTH) || ra);
        wren1 = wr; wrdata1 = d; rden1 = rd;
        if (ra) void'(fq.pop_front());
        if (wa) fq.push_back(d);
        if (wa && !ra) m1_cnt++;
        else if (ra && !wa) m1_cnt--;
        @(posedge clk); #1;
        wren1 = 1'b0; rden1 = 1'b0;
        chk1(wr && !wa, rd && !ra);
    endtask

    // Reset the standard-read instance; requests held during reset must be ignored.
    task automatic reset0(input logic wr, input logic rd);
        rst0 = 1'b1; wren0 = wr; rden0 = rd; wrdata0 = 8'hEE;
        @(posedge clk); #1;
        rst0 = 1'b0; wren0 = 1'b0; rden0 = 1'b0;
        exp_q.delete(); m0_cnt = 0; m0_last = '0;
        chk0(1'b0, 1'b0);
    endtask

    task automatic reset1(input logic wr, input logic rd);
        rst1 = 1'b1; wren1 = wr; rden1 = rd; wrdata1 = 8'hEE;
        @(posedge clk); #1;
        rst1 = 1'b0; wren1 = 1'b0; rden1 = 1'b0;
        fq.delete(); m1_cnt = 0;
        chk1(1'b0, 1'b0);
    endtask

    // Directed sequence.
    initial begin
        rst0 = 1'b1; wren0 = 1'b0; rden0 = 1'b0; wrdata0 = '0;
        rst1 = 1'b1; wren1 = 1'b0; rden1 = 1'b0; wrdata1 = '0;
        m0_cnt = 0; m1_cnt = 0; m0_last = '0;
        #1;

        // Reset state and fill/drain with threshold sweep on every step.
        reset0(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc0(1'b1, DW'(i), 1'b0);

        // Overflow on full, then write+read together while full.
        cyc0(1'b1, 8'h77, 1'b0);
        cyc0(1'b0, 8'h00, 1'b0);
        cyc0(1'b1, 8'h99, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc0(1'b0, 8'h00, 1'b1);

        // Underflow on empty, then read+write together while empty.
        cyc0(1'b0, 8'h00, 1'b1);
        cyc0(1'b0, 8'h00, 1'b0);
        cyc0(1'b1, 8'hA5, 1'b1);
        cyc0(1'b0, 8'h00, 1'b1);

        // Pointer wrap: interleaved write/read pairs.
        for (int i = 0; i < 40; i++) begin
            cyc0(1'b1, DW'($urandom_range(0, 255)), 1'b0);
            cyc0(1'b0, 8'h00, 1'b1);
        end

        // Random mixed traffic.
        for (int i = 0; i < 200; i++) begin
            cyc0(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        // Reset mid-traffic with requests asserted.
        for (int i = 0; i < 5; i++) cyc0(1'b1, DW'(8'h40 + i), 1'b0);
        reset0(1'b1, 1'b1);
        cyc0(1'b1, 8'h5C, 1'b0);
        cyc0(1'b0, 8'h00, 1'b1);

        // Fall-through instance.
        reset1(1'b0, 1'b0);
        cyc1(1'b1, 8'h11, 1'b0);
        chk("fwft_first_word", 32'(rddata1), 32'h11);
        cyc1(1'b1, 8'h22, 1'b0);
        cyc1(1'b0, 8'h00, 1'b1);
        chk("fwft_after_pop", 32'(rddata1), 32'h22);
        for (int i = 0; i < 4; i++) cyc1(1'b1, DW'(8'h30 + i), 1'b0);
        reset1(1'b1, 1'b1);
        cyc1(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) cyc1(1'b1, DW'(8'h80 + i), 1'b0);
        for (int i = 0; i < 150; i++) begin
            cyc1(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        // Report.
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO that supersedes the fixed 128-bit FIFO in the datapath.
- Data width and depth are parameters; almost-full/almost-empty thresholds are parameters.
- Adds a fill-level output, single-cycle overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer stages in one clock domain; the existing FIFO UVM agents drive and monitor it through the same interface signal set plus the new outputs.

Parameters:
DATA_W, 128, width of i_wrdata/o_rddata in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
ALM_FULL_TH, 14, o_alm_full asserted when count >= ALM_FULL_TH (1..DEPTH-1)
ALM_EMPTY_TH, 2, o_alm_empty asserted when count <= ALM_EMPTY_TH (1..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_wren  input  1  write request
i_wrdata  input  DATA_W  write data
i_rden  input  1  read request
o_rddata  output  DATA_W  read data
o_full  output  1  count == DEPTH
o_alm_full  output  1  count >= ALM_FULL_TH
o_empty  output  1  count == 0
o_alm_empty  output  1  count <= ALM_EMPTY_TH
o_count  output  $clog2(DEPTH)+1  current fill level
o_overflow  output  1  one-cycle pulse: write rejected
o_underflow  output  1  one-cycle pulse: read rejected

Behaviour:
Reset (clk edge with reset=1):
- wr_ptr = rd_ptr = count = 0; o_rddata = 0; o_overflow = o_underflow = 0.
- Flags then read o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
- Memory contents are not cleared.
- Reset mid-traffic discards all entries; requests in the reset cycle are ignored and raise no error pulse.

Pointers and arithmetic:
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is a separate register; all flags decode combinationally from count, so they update in the cycle after the accepting edge.

Acceptance, evaluated on the pre-edge state:
- rd_acc = i_rden & ~o_empty.
- wr_acc = i_wren & (~o_full | rd_acc).
- A write while full is accepted only when a simultaneous read is accepted; count is then unchanged.
- Read while empty is rejected even with a simultaneous write; the write is still accepted.

Count update:
- wr_acc only: +1. rd_acc only: -1. Both or neither: unchanged.

Errors:
- o_overflow = 1 for exactly the cycle after an edge where i_wren=1 and wr_acc=0.
- o_underflow likewise for i_rden=1 and rd_acc=0.
- Both pulses are registered and self-clear.

FWFT=0 (standard read):
- On rd_acc, o_rddata is loaded with mem[rd_ptr] and is valid the cycle after the request (1-cycle latency).
- o_rddata holds its last value otherwise.

FWFT=1 (fall-through):
- o_rddata = mem[rd_ptr] combinationally whenever o_empty=0.
- A word written into an empty FIFO appears the cycle after its write edge.
- i_rden acts as an acknowledge that pops the head; the next word is visible in the following cycle.
- o_rddata is don't-care while o_empty=1; the bench must not check it then.

Write data: on wr_acc, mem[wr_ptr] <= i_wrdata.

Memory: no bypass from write to read in the same cycle, in either mode.

Test Plan:
- Reset, then 16 writes of 0x0..0xF, then 16 reads (FWFT=0) -> o_rddata = 0x0..0xF in order, each 1 cycle after its i_rden. o_full=1 after the 16th write; o_empty=1 after the 16th read. o_count steps 0→16→0.
- Threshold sweep (ALM_FULL_TH=14, ALM_EMPTY_TH=2) -> o_alm_empty=1 at count 0..2 and 0 at 3. o_alm_full=0 at 13 and 1 at 14..16.
- Full FIFO, i_wren=1 alone -> write dropped, o_overflow=1 for one cycle, count stays 16. Then i_wren=i_rden=1 -> both accepted, count stays 16, the new word read out 16 reads later.
- Empty FIFO, i_rden=1 -> o_underflow=1 for one cycle, count 0. Then i_rden=i_wren=1 with data 0xA5 -> write accepted, underflow pulse, count=1.
- Pointer wrap: 40 interleaved write/read pairs through DEPTH=16 -> output sequence matches input with no loss or duplication.
- FWFT=1: write 0x11 into empty FIFO -> o_rddata=0x11 and o_empty=0 the next cycle. Write 0x22, pulse i_rden -> o_rddata=0x22 the next cycle. Assert reset with 5 entries -> o_empty=1, o_count=0 the next cycle.
